// File: rtl/f1_start_seq.sv
// F1 start-light sequencer: lights fill one per tick, hold for a random or fixed
// number of ticks, go dark, then time the driver's reaction in clock cycles.
module f1_start_seq #(
    parameter int WIDTH      = 8,
    parameter int DELAY_W    = 4,
    parameter int RT_W       = 16,
    parameter int RANDOM     = 1,
    parameter int HOLD_FIXED = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic             tick,
    input  logic             react,
    output logic [WIDTH-1:0] out,
    output logic             lights_out,
    output logic             react_valid,
    output logic [RT_W-1:0]  react_time,
    output logic             jump_start,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, FILL, HOLD, TIMING} state_t;

    localparam logic [RT_W-1:0]    RT_MAX = '1;
    localparam logic [DELAY_W-1:0] HOLD_F = DELAY_W'(HOLD_FIXED);

    state_t             r_state;
    logic [WIDTH-1:0]   r_out;
    logic [DELAY_W-1:0] r_hold;
    logic [RT_W-1:0]    r_cnt;
    logic [RT_W-1:0]    r_rt;
    logic [6:0]         r_lfsr;
    logic               r_lo;
    logic               r_rv;
    logic               r_js;
    logic               r_busy;

    logic [DELAY_W-1:0] w_rand;
    logic [DELAY_W-1:0] w_hold_load;

    // A zero hold would never extinguish, so it is promoted to one tick.
    assign w_rand      = (r_lfsr[DELAY_W-1:0] == '0) ? DELAY_W'(1) : r_lfsr[DELAY_W-1:0];
    assign w_hold_load = (RANDOM != 0) ? w_rand : HOLD_F;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_out   <= '0;
            r_hold  <= '0;
            r_cnt   <= '0;
            r_rt    <= '0;
            r_lfsr  <= 7'h01;
            r_lo    <= 1'b0;
            r_rv    <= 1'b0;
            r_js    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
            r_lo   <= 1'b0;
            r_rv   <= 1'b0;
            r_js   <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_out <= '0;
                    if (trigger) begin
                        r_state <= FILL;
                        r_busy  <= 1'b1;
                    end
                end
                FILL, HOLD: begin
                    // react outranks tick: an early press is always a jump start
                    if (react) begin
                        r_js    <= 1'b1;
                        r_out   <= '0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (tick) begin
                        if (r_state == FILL) begin
                            r_out <= {r_out[WIDTH-2:0], 1'b1};
                            if (&r_out[WIDTH-2:0]) begin
                                r_hold  <= w_hold_load;
                                r_state <= HOLD;
                            end
                        end else if (r_hold == DELAY_W'(1)) begin
                            r_out   <= '0;
                            r_lo    <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= TIMING;
                        end else begin
                            r_hold <= r_hold - DELAY_W'(1);
                        end
                    end
                end
                TIMING: begin
                    if (react) begin
                        r_rt    <= r_cnt;
                        r_rv    <= 1'b1;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt != RT_MAX) begin
                        r_cnt <= r_cnt + RT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out         = r_out;
    assign lights_out  = r_lo;
    assign react_valid = r_rv;
    assign react_time  = r_rt;
    assign jump_start  = r_js;
    assign busy        = r_busy;

endmodule

// File: tb/tb_f1_start_seq.sv
// Bench for f1_start_seq: three configurations checked every cycle against a
// count-based behavioural model, plus directed literal expectations.
module tb_f1_start_seq;

    logic clk, rst;
    logic [2:0] trg, tck, rct;

    logic [7:0]  o0, o2;
    logic [2:0]  o1;
    logic [15:0] rt0, rt2;
    logic [3:0]  rt1;
    logic lo0, lo1, lo2, rv0, rv1, rv2, js0, js1, js2, bz0, bz1, bz2;

    int checks = 0;
    int errors = 0;

    f1_start_seq #(.WIDTH(8), .DELAY_W(4), .RT_W(16), .RANDOM(0), .HOLD_FIXED(3)) dut0 (
        .clk(clk), .rst(rst), .trigger(trg[0]), .tick(tck[0]), .react(rct[0]),
        .out(o0), .lights_out(lo0), .react_valid(rv0), .react_time(rt0),
        .jump_start(js0), .busy(bz0));
    f1_start_seq #(.WIDTH(3), .DELAY_W(4), .RT_W(4), .RANDOM(0), .HOLD_FIXED(1)) dut1 (
        .clk(clk), .rst(rst), .trigger(trg[1]), .tick(tck[1]), .react(rct[1]),
        .out(o1), .lights_out(lo1), .react_valid(rv1), .react_time(rt1),
        .jump_start(js1), .busy(bz1));
    f1_start_seq #(.WIDTH(8), .DELAY_W(4), .RT_W(16), .RANDOM(1), .HOLD_FIXED(3)) dut2 (
        .clk(clk), .rst(rst), .trigger(trg[2]), .tick(tck[2]), .react(rct[2]),
        .out(o2), .lights_out(lo2), .react_valid(rv2), .react_time(rt2),
        .jump_start(js2), .busy(bz2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode: 0 idle, 1 filling, 2 fully lit, 3 timing; lit = number of lamps on
    typedef struct {
        int mode, lit, hold, hinit, cnt, rt, lfsr;
        bit lo, rv, js;
    } model_t;

    model_t m0, m1, m2;

    function automatic model_t mreset();
        model_t m;
        m = '{default: 0};
        m.lfsr = 1;
        return m;
    endfunction

    function automatic model_t step(model_t m, int w, int rtw, bit rnd, int hf,
                                    bit tg, bit tk, bit rc);
        model_t n = m;
        int r;
        n.lo = 0; n.rv = 0; n.js = 0;
        n.lfsr = ((m.lfsr * 2) % 128) + (((m.lfsr / 64) + (m.lfsr / 32)) % 2);
        if (m.mode == 0) begin
            if (tg) n.mode = 1;
        end else if (m.mode == 3) begin
            if (rc) begin
                n.rt = m.cnt; n.rv = 1; n.mode = 0;
            end else if (m.cnt < (1 << rtw) - 1) n.cnt = m.cnt + 1;
        end else if (rc) begin
            n.js = 1; n.mode = 0; n.lit = 0;
        end else if (tk && m.mode == 1) begin
            n.lit = m.lit + 1;
            if (n.lit == w) begin
                r = m.lfsr % 16;
                n.hold = rnd ? ((r == 0) ? 1 : r) : hf;
                n.hinit = n.hold;
                n.mode = 2;
            end
        end else if (tk) begin
            n.hold = m.hold - 1;
            if (n.hold == 0) begin
                n.mode = 3; n.lit = 0; n.lo = 1; n.cnt = 0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m0 = mreset(); m1 = mreset(); m2 = mreset();
        end else begin
            m0 = step(m0, 8, 16, 0, 3, trg[0], tck[0], rct[0]);
            m1 = step(m1, 3, 4, 0, 1, trg[1], tck[1], rct[1]);
            m2 = step(m2, 8, 16, 1, 3, trg[2], tck[2], rct[2]);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 25) $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input int id, input logic [7:0] o, input logic lo, input logic rv,
                       input logic [15:0] rt, input logic js, input logic bz, input model_t m);
        chk($sformatf("d%0d_out", id), {24'd0, o}, (1 << m.lit) - 1);
        chk($sformatf("d%0d_lights_out", id), {31'd0, lo}, {31'd0, m.lo});
        chk($sformatf("d%0d_react_valid", id), {31'd0, rv}, {31'd0, m.rv});
        chk($sformatf("d%0d_react_time", id), {16'd0, rt}, m.rt);
        chk($sformatf("d%0d_jump_start", id), {31'd0, js}, {31'd0, m.js});
        chk($sformatf("d%0d_busy", id), {31'd0, bz}, {31'd0, m.mode != 0});
    endtask

    always @(negedge clk) begin
        cmp(0, o0, lo0, rv0, rt0, js0, bz0, m0);
        cmp(1, {5'd0, o1}, lo1, rv1, {12'd0, rt1}, js1, bz1, m1);
        cmp(2, o2, lo2, rv2, rt2, js2, bz2, m2);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int i);
        tck[i] = 1'b1;
        cyc();
        tck[i] = 1'b0;
    endtask

    initial begin
        model_t t;
        int meas;
        bit found;
        trg = '0; tck = '0; rct = '0;
        rst = 1'b0;
        m0 = mreset(); m1 = mreset(); m2 = mreset();

        // pin the model's LFSR to hand-derived values
        t = mreset();
        repeat (7) t = step(t, 8, 16, 0, 3, 1'b0, 1'b0, 1'b0);
        chk("model_lfsr7", t.lfsr, 32'h03);
        repeat (5) t = step(t, 8, 16, 0, 3, 1'b0, 1'b0, 1'b0);
        chk("model_lfsr12", t.lfsr, 32'h61);

        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        chk("reset_out", {24'd0, o0}, 0);
        chk("reset_busy", {31'd0, bz0}, 0);
        chk("reset_rt", {16'd0, rt0}, 0);

        // fill, tick coincident with trigger is not counted
        trg[0] = 1'b1; tck[0] = 1'b1;
        cyc();
        trg[0] = 1'b0; tck[0] = 1'b0;
        chk("trig_tick_out", {24'd0, o0}, 0);
        chk("trig_busy", {31'd0, bz0}, 1);
        for (int i = 1; i <= 8; i++) begin
            tick(0);
            chk("fill_out", {24'd0, o0}, (1 << i) - 1);
        end
        tick(0); tick(0);
        chk("hold_out", {24'd0, o0}, 32'hff);
        tick(0);
        chk("lights_out_pulse", {31'd0, lo0}, 1);
        chk("lights_out_dark", {24'd0, o0}, 0);
        cyc();
        chk("lights_out_once", {31'd0, lo0}, 0);
        repeat (24) cyc();
        rct[0] = 1'b1;
        cyc();
        rct[0] = 1'b0;
        chk("react_valid", {31'd0, rv0}, 1);
        chk("react_time_25", {16'd0, rt0}, 25);
        chk("react_busy", {31'd0, bz0}, 0);
        cyc();
        chk("react_valid_once", {31'd0, rv0}, 0);

        // trigger with react in IDLE starts; react in HOLD is a jump start
        trg[0] = 1'b1; rct[0] = 1'b1;
        cyc();
        trg[0] = 1'b0; rct[0] = 1'b0;
        chk("trig_react_busy", {31'd0, bz0}, 1);
        repeat (8) tick(0);
        rct[0] = 1'b1;
        cyc();
        rct[0] = 1'b0;
        chk("jump_pulse", {31'd0, js0}, 1);
        chk("jump_out", {24'd0, o0}, 0);
        chk("jump_busy", {31'd0, bz0}, 0);
        chk("jump_rt_kept", {16'd0, rt0}, 25);

        trg[0] = 1'b1;
        cyc();
        trg[0] = 1'b0;
        repeat (8) tick(0);
        tick(0); tick(0);
        tck[0] = 1'b1; rct[0] = 1'b1;
        cyc();
        tck[0] = 1'b0; rct[0] = 1'b0;
        chk("jump_vs_tick_js", {31'd0, js0}, 1);
        chk("jump_vs_tick_lo", {31'd0, lo0}, 0);

        // asynchronous reset mid-fill
        trg[0] = 1'b1;
        cyc();
        trg[0] = 1'b0;
        repeat (3) tick(0);
        chk("pre_reset_out", {24'd0, o0}, 32'h07);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_out", {24'd0, o0}, 0);
        chk("async_reset_busy", {31'd0, bz0}, 0);
        chk("async_reset_rt", {16'd0, rt0}, 0);
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b1;
        cyc();
        chk("post_reset_busy", {31'd0, bz0}, 0);

        // WIDTH=3, RT_W=4: fill 1,3,7 then saturating reaction counter
        trg[1] = 1'b1;
        cyc();
        trg[1] = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            chk("w3_fill", {29'd0, o1}, (1 << i) - 1);
        end
        tick(1);
        chk("w3_lights_out", {31'd0, lo1}, 1);
        repeat (40) cyc();
        rct[1] = 1'b1;
        cyc();
        rct[1] = 1'b0;
        chk("sat_rt", {28'd0, rt1}, 15);
        chk("sat_valid", {31'd0, rv1}, 1);

        // random hold runs
        for (int run = 0; run < 20; run++) begin
            trg[2] = 1'b1;
            cyc();
            trg[2] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                repeat ($urandom_range(0, 2)) cyc();
                tick(2);
                if (run == 5 && i == 3) begin
                    trg[2] = 1'b1;
                    cyc();
                    trg[2] = 1'b0;
                end
            end
            chk("rand_full", {24'd0, o2}, 32'hff);
            found = 0; meas = 0;
            for (int k = 1; k <= 20; k++) begin
                if (!found) begin
                    tick(2);
                    meas = k;
                    if (lo2) found = 1;
                end
            end
            chk("rand_hold_timeout", {31'd0, found}, 1);
            chk("rand_hold_range", {31'd0, (meas >= 1 && meas <= 15)}, 1);
            chk("rand_hold_model", meas, m2.hinit);
            repeat ($urandom_range(0, 10)) cyc();
            rct[2] = 1'b1;
            cyc();
            rct[2] = 1'b0;
            chk("rand_react_valid", {31'd0, rv2}, 1);
        end

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
